// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle WIDTH-bit adder using one 4-bit carry-lookahead slice
//
// Purpose: adds a + b + ci one nibble per clock. Operands are captured when
// start is accepted (in IDLE or DONE), then NIB RUN cycles each push one
// nibble through the CLA slice, chaining the carry through a register.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, accepted in IDLE or DONE, ignored in RUN
//   a, b   in   WIDTH-bit operands, captured on an accepted start
//   ci     in   carry-in, captured on an accepted start
//   busy   out  high while nibbles are being computed
//   done   out  one-cycle pulse when sum/co/ovf are valid
//   sum    out  WIDTH-bit result, held until the next accepted start
//   co     out  carry-out of bit WIDTH-1
//   ovf    out  two's-complement overflow
//
// WIDTH must be a multiple of 4 and at least 8.

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             cr_q, cr_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    // Carry-lookahead slice on the current nibble
    logic [3:0] nib_a, nib_b, nib_p, nib_g, nib_s;
    logic       c1, c2, c3, c4;

    always_comb begin
        nib_a = a_q[{idx_q, 2'b00} +: 4];
        nib_b = b_q[{idx_q, 2'b00} +: 4];
        nib_p = nib_a ^ nib_b;
        nib_g = nib_a & nib_b;
        c1 = nib_g[0] | (nib_p[0] & cr_q);
        c2 = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & cr_q);
        c3 = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
           | (nib_p[2] & nib_p[1] & nib_p[0] & cr_q);
        c4 = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
           | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
           | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & cr_q);
        nib_s = nib_p ^ {c3, c2, c1, cr_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        cr_d    = cr_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        if (state_q == S_RUN) begin
            // start is deliberately not looked at here
            sum_d[{idx_q, 2'b00} +: 4] = nib_s;
            cr_d  = c4;
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(NIB - 1)) begin
                // c3 is the carry into the MSB of the whole word on the last nibble
                co_d    = c4;
                ovf_d   = c3 ^ c4;
                idx_d   = '0;
                state_d = S_DONE;
            end
        end else if (start) begin
            a_d     = a;
            b_d     = b;
            cr_d    = ci;
            idx_d   = '0;
            sum_d   = '0;
            co_d    = 1'b0;
            ovf_d   = 1'b0;
            state_d = S_RUN;
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            cr_q    <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            cr_q    <= cr_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign co   = co_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed vector bench for nibble_serial_adder

module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        ci;
    logic        busy, done;
    logic [15:0] sum;
    logic        co, ovf;

    int tests  = 0;
    int failed = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .sum(sum), .co(co), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] sum;
        logic        co;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle, expect done exactly 4 cycles after acceptance
    task automatic run_vec(input string name, input vec_t v);
        int n;
        bit seen;
        bit busy_ok;
        a = v.a; b = v.b; ci = v.ci; start = 1'b1;
        tick();
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; ci = ~v.ci;
        chk({name, " busy_after_accept"}, {31'd0, busy}, 32'd1);
        n = 0; seen = 0; busy_ok = 1;
        while (!seen && n < 10) begin
            tick();
            n++;
            if (done) seen = 1;
            else if (!busy) busy_ok = 0;
        end
        chk({name, " latency"}, n, 4);
        chk({name, " busy_during_run"}, {31'd0, busy_ok}, 32'd1);
        chk({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({name, " sum"}, {16'd0, sum}, {16'd0, v.sum});
        chk({name, " co"}, {31'd0, co}, {31'd0, v.co});
        chk({name, " ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
        tick();
        chk({name, " done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({name, " sum_held"}, {16'd0, sum}, {16'd0, v.sum});
    endtask

    vec_t vecs[7];

    initial begin
        int n;
        int pulses;
        int last_pulse;
        bit seen;
        vec_t v;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset sum", {16'd0, sum}, 32'd0);
        chk("reset co", {31'd0, co}, 32'd0);
        chk("reset ovf", {31'd0, ovf}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // start during RUN is ignored
        a = 16'h00F0; b = 16'h0010; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 16'hAAAA; b = 16'h5555; ci = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 2; seen = 0;
        while (!seen && n < 10) begin
            if (done) seen = 1;
            else begin tick(); n++; end
        end
        chk("ignore_start latency", n, 4);
        chk("ignore_start sum", {16'd0, sum}, 32'h0100);
        chk("ignore_start co", {31'd0, co}, 32'd0);
        tick();
        chk("ignore_start no_restart", {30'd0, busy, done}, 32'd0);

        // start held high: one result every 5 cycles
        a = 16'h8000; b = 16'h8000; ci = 1'b0; start = 1'b1;
        tick();
        pulses = 0; last_pulse = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (done) begin
                pulses++;
                chk($sformatf("b2b pulse%0d cycle", pulses), c, 5 * pulses - 1);
                chk("b2b sum", {16'd0, sum}, 32'd0);
                chk("b2b co", {31'd0, co}, 32'd1);
                chk("b2b ovf", {31'd0, ovf}, 32'd1);
                last_pulse = c;
            end
        end
        chk("b2b pulse count", pulses, 3);
        start = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 10) begin
            tick(); n++;
            if (done) seen = 1;
        end
        chk("b2b drain done", {31'd0, seen}, 32'd1);
        tick();

        // reset in the third RUN cycle aborts
        a = 16'h1111; b = 16'h2222; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort sum", {16'd0, sum}, 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done || busy) seen = 1;
        end
        chk("abort no_done", {31'd0, seen}, 32'd0);
        v = '{16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0};
        run_vec("after_abort", v);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
